// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced speed/mode buttons driving blink-speed preset and LED mask.
// Optional feature macro: LED_CHASE_EN (adds CHASE mode with rotating mask).
// Latency: raw press -> press pulse DB_CYCLES+3 edges; outputs update one cycle later.
module led_mode_ctrl #(
  parameter int N         = 27,
  parameter int DB_CYCLES = 1000000,
  parameter int SPD0      = 100000000,
  parameter int SPD1      = 50000000,
  parameter int SPD2      = 25000000,
  parameter int SPD3      = 12500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_speed,
  input  logic         btn_mode,
  input  logic         blink_tick,
  output logic [N-1:0] speed_sel,
  output logic [1:0]   speed_idx,
  output logic [1:0]   mode,
  output logic [3:0]   led_mask
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ALL   = 2'b00,
    ST_CHASE = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Bit 0 is the speed button, bit 1 the mode button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    sync_vld;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    armed;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];
  state_t        state;

  assign raw  = {btn_mode, btn_speed};
  assign mode = state;

  function automatic logic [N-1:0] spd_lut(input logic [1:0] idx);
    logic [N-1:0] v;
    case (idx)
      2'd0:    v = N'(SPD0);
      2'd1:    v = N'(SPD1);
      2'd2:    v = N'(SPD2);
      default: v = N'(SPD3);
    endcase
    return v;
  endfunction

  // Two-flop synchronizers; sync_vld marks when sync2 carries post-reset samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Debouncers: count consecutive disagreeing samples, adopt the new level at CNT_MAX.
  // A button is armed only after a real released sample, so a button held through
  // reset must be released and pressed again before it can produce a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      armed  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_vld[1] && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Single-cycle press pulse on a rising edge of the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d & armed;
    end
  end

  // Speed preset index and its registered lookup value advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_idx <= 2'd0;
      speed_sel <= N'(SPD0);
    end else if (press[0]) begin
      speed_idx <= speed_idx + 2'd1;
      speed_sel <= spd_lut(speed_idx + 2'd1);
    end
  end

`ifndef LED_CHASE_EN
  // Without CHASE the blink tick has no consumer.
  logic unused_blink_tick;
  assign unused_blink_tick = blink_tick;
`endif

  // Mode FSM with registered LED mask; a mode press always beats a blink tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ALL;
      led_mask <= 4'b1111;
    end else begin
      case (state)
        ST_ALL: begin
          if (press[1]) begin
`ifdef LED_CHASE_EN
            state    <= ST_CHASE;
            led_mask <= 4'b0001;
`else
            state    <= ST_PAUSE;
            led_mask <= 4'b0000;
`endif
          end
        end
`ifdef LED_CHASE_EN
        ST_CHASE: begin
          if (press[1]) begin
            state    <= ST_PAUSE;
            led_mask <= 4'b0000;
          end else if (blink_tick) begin
            led_mask <= {led_mask[2:0], led_mask[3]};
          end
        end
`endif
        ST_PAUSE: begin
          if (press[1]) begin
            state    <= ST_ALL;
            led_mask <= 4'b1111;
          end
        end
        default: begin
          state    <= ST_ALL;
          led_mask <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter N, default 27: width of the speed_sel output.
REQ-002 Parameter DB_CYCLES, default 1000000: debounce qualification length in clocks, legal range 2..2^24.
REQ-003 Parameters SPD0..SPD3, defaults 100000000 / 50000000 / 25000000 / 12500000: blink-timer max_count presets, each < 2^N.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 btn_speed  in  1  raw pushbutton, asynchronous to clk, active-high.
REQ-007 btn_mode  in  1  raw pushbutton, asynchronous to clk, active-high.
REQ-008 blink_tick  in  1  one-cycle pulse from the blink timer enable, synchronous to clk.
REQ-009 speed_sel  out  N  preset value driving the blink timer max_count.
REQ-010 speed_idx  out  2  current preset index.
REQ-011 mode  out  2  current mode: 00 ALL, 01 CHASE, 10 PAUSE; 11 never driven.
REQ-012 led_mask  out  4  per-LED enable mask, ANDed with the blinker outputs downstream.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then its own debouncer.
REQ-014 Debouncer: counter clears whenever synced value equals the stable state; otherwise it increments; on reaching DB_CYCLES-1 the stable state takes the synced value and the counter clears.
REQ-015 A press pulse SHALL be one registered cycle on a 0->1 transition of the stable state only; release and held buttons produce no further pulses.
REQ-016 Latency: raw 0->1 held steady SHALL yield its press pulse exactly DB_CYCLES+3 rising edges after the first edge sampling the new level.
REQ-017 Glitches shorter than DB_CYCLES synced cycles SHALL produce no pulse and leave the stable state unchanged.
REQ-018 On a speed press, speed_idx SHALL increment modulo 4 (3 wraps to 0) in the following cycle.
REQ-019 speed_sel SHALL be registered, equal SPD[speed_idx], and update in the same cycle as speed_idx.
REQ-020 Mode FSM on mode press: ALL->CHASE->PAUSE->ALL; there is no other transition.
REQ-021 ALL: led_mask=1111, blink_tick ignored.
REQ-022 CHASE entry: led_mask=0001 in the same cycle mode becomes 01.
REQ-023 In CHASE, each blink_tick SHALL rotate led_mask left by one (1000 wraps to 0001).
REQ-024 PAUSE: led_mask=0000, blink_tick ignored.
REQ-025 Mode press coincident with blink_tick in CHASE: the transition wins and no rotation occurs.
REQ-026 Speed and mode presses in the same cycle SHALL both take effect in the same following cycle.
REQ-027 A speed change SHALL NOT alter mode or led_mask.

Reset
REQ-028 While rst=1, registers SHALL hold: synchronizers 0, stable states 0, debounce counters 0, speed_idx=0, speed_sel=SPD0, mode=00, led_mask=1111.
REQ-029 Reset asserted mid-debounce or mid-chase SHALL discard all progress; after release, a still-held button requires a release and a new press to generate a pulse.

Configuration
REQ-030 Macro LED_CHASE_EN defined: CHASE mode is present as specified above.
REQ-031 Macro LED_CHASE_EN undefined: FSM is ALL<->PAUSE on each mode press, mode is never 01, blink_tick has no effect, and no rotation logic is built.

Verification (bench uses DB_CYCLES=4, SPD0..3 = 40/20/10/5, N=8, LED_CHASE_EN defined unless stated)
REQ-032 Reset, then btn_speed held high 20 cycles -> exactly one pulse at edge 7 (4+3); speed_idx 0->1; speed_sel 40->20; mode=00 and led_mask=1111 unchanged.
REQ-033 Four clean speed presses -> speed_sel sequence 20,10,5,40; speed_idx wraps 3->0.
REQ-034 btn_mode high-low glitch of 3 cycles -> no pulse and no state change; then a clean press -> mode=01, led_mask=0001; three blink_ticks -> 0010,0100,1000; fourth -> 0001.
REQ-035 In CHASE with led_mask=0100, mode pulse and blink_tick in the same cycle -> mode=10, led_mask=0000; later blink_ticks -> mask stays 0000; next press -> mode=00, mask=1111.
REQ-036 rst pulsed while speed_idx=2 and btn_speed held mid-debounce -> outputs return to reset values asynchronously; no pulse until the button is released and pressed again.
REQ-037 LED_CHASE_EN undefined, three mode presses -> mode 00->10->00->10; blink_ticks leave led_mask at 1111 or 0000.
